// File: rtl/tank_sprite_gen_if.sv
// -----------------------------------------------------------------------------
// tank_sprite_gen_if
// Bundle between the VGA timing stage (master) and the sprite pixel source
// (slave).
//   vga_vs      : vertical sync, active-low              (master -> slave)
//   pause       : freeze sprite motion while high        (master -> slave)
//   pixel_xpos  : requested column, 0..639 or 0          (master -> slave)
//   pixel_ypos  : requested line + 1, 1..480, 0 = blank  (master -> slave)
//   pixel_data  : RGB565, one clock after the request    (slave -> master)
//   blk_x/blk_y : sprite top-left corner                 (slave -> master)
//   frame_tick  : one-cycle pulse per vsync start         (slave -> master)
// -----------------------------------------------------------------------------
interface tank_sprite_gen_if;
  logic        vga_vs;
  logic        pause;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic [15:0] pixel_data;
  logic [9:0]  blk_x;
  logic [9:0]  blk_y;
  logic        frame_tick;

  modport master (
    output vga_vs, pause, pixel_xpos, pixel_ypos,
    input  pixel_data, blk_x, blk_y, frame_tick
  );

  modport slave (
    input  vga_vs, pause, pixel_xpos, pixel_ypos,
    output pixel_data, blk_x, blk_y, frame_tick
  );
endinterface

// File: rtl/tank_sprite_gen.sv
// -----------------------------------------------------------------------------
// tank_sprite_gen
// Pixel source for a 640x480 VGA picture: background, fixed border and one
// square sprite that moves once per FRAME_DIV frames and bounces off the
// inner edge of the border. Position only changes during vertical sync, so a
// frame is never drawn with two different sprite positions.
//
// Ports:
//   vga_clk : pixel clock
//   sys_rst : asynchronous, active-high reset
//   bus     : tank_sprite_gen_if.slave
//             in : vga_vs, pause, pixel_xpos, pixel_ypos
//             out: pixel_data (1-cycle latency), blk_x, blk_y, frame_tick
// -----------------------------------------------------------------------------
module tank_sprite_gen #(
  parameter int          H_DISP       = 640,
  parameter int          V_DISP       = 480,
  parameter int          BORDER       = 8,
  parameter int          BLK_SIZE     = 32,
  parameter int          STEP         = 2,
  parameter int          FRAME_DIV    = 1,
  parameter logic [15:0] BG_COLOR     = 16'hFFFF,
  parameter logic [15:0] BORDER_COLOR = 16'h001F,
  parameter logic [15:0] BLK_COLOR    = 16'hF800
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  tank_sprite_gen_if.slave bus
);

  // Geometry held as 11-bit signed so sums and differences never wrap.
  localparam logic signed [10:0] XMIN   = 11'(BORDER);
  localparam logic signed [10:0] XMAX   = 11'(H_DISP - BORDER - BLK_SIZE);
  localparam logic signed [10:0] YMIN   = 11'(BORDER);
  localparam logic signed [10:0] YMAX   = 11'(V_DISP - BORDER - BLK_SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] BLK_S  = 11'(BLK_SIZE);
  localparam logic signed [10:0] BRD_S  = 11'(BORDER);
  localparam logic signed [10:0] H_EDGE = 11'(H_DISP - BORDER);
  localparam logic signed [10:0] V_EDGE = 11'(V_DISP - BORDER);

  localparam logic [9:0] XMIN_U = 10'(BORDER);
  localparam logic [9:0] YMIN_U = 10'(BORDER);

  localparam int                CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_DIV - 1);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;  // 0: increasing, 1: decreasing
  } axis_t;

  // One move of one axis: step, or clamp to the limit and reverse when the
  // step would reach or cross it.
  function automatic axis_t step_axis(
    input logic [9:0]         pos,
    input logic               dir,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi
  );
    logic signed [10:0] p;
    axis_t              r;
    p     = $signed({1'b0, pos});
    r.pos = pos;
    r.dir = dir;
    if (!dir) begin
      if (p + STEP_S >= hi) begin
        r.pos = hi[9:0];
        r.dir = 1'b1;
      end else begin
        r.pos = 10'(p + STEP_S);
      end
    end else begin
      if (p <= lo + STEP_S) begin
        r.pos = lo[9:0];
        r.dir = 1'b0;
      end else begin
        r.pos = 10'(p - STEP_S);
      end
    end
    return r;
  endfunction

  // Colour of one requested pixel; ypos carries line+1 so 0 means blanking.
  function automatic logic [15:0] pixel_color(
    input logic [9:0] xpos,
    input logic [9:0] ypos,
    input logic [9:0] bx,
    input logic [9:0] by
  );
    logic signed [10:0] col;
    logic signed [10:0] row;
    logic signed [10:0] sx;
    logic signed [10:0] sy;
    logic               in_blk;
    logic               in_brd;
    logic [15:0]        c;
    col    = $signed({1'b0, xpos});
    row    = $signed({1'b0, ypos}) - 11'sd1;
    sx     = $signed({1'b0, bx});
    sy     = $signed({1'b0, by});
    in_blk = (col >= sx) && (col < sx + BLK_S) &&
             (row >= sy) && (row < sy + BLK_S);
    in_brd = (col < BRD_S) || (col >= H_EDGE) ||
             (row < BRD_S) || (row >= V_EDGE);
    if (ypos == 10'd0) begin
      c = 16'h0000;
    end else if (in_blk) begin
      c = BLK_COLOR;
    end else if (in_brd) begin
      c = BORDER_COLOR;
    end else begin
      c = BG_COLOR;
    end
    return c;
  endfunction

  logic             r_vs_q;
  logic             r_armed;
  logic             r_frame_tick;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [9:0]       r_blk_x;
  logic [9:0]       r_blk_y;
  logic             r_dir_x;
  logic             r_dir_y;
  logic [15:0]      r_pixel_data_p1;

  logic             w_move;
  axis_t            w_next_x;
  axis_t            w_next_y;
  logic [15:0]      w_pixel_p0;

  // ---- frame detect ---------------------------------------------------------
  // r_armed stays low until vga_vs has been seen high after reset, so a sync
  // pulse already in progress at reset release does not count as a frame.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_vs_q       <= 1'b1;
      r_armed      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_q       <= bus.vga_vs;
      r_armed      <= r_armed | bus.vga_vs;
      r_frame_tick <= r_vs_q & ~bus.vga_vs & r_armed;
    end
  end

  // ---- frame divider and sprite motion --------------------------------------
  assign w_move   = r_frame_tick & ~bus.pause & (r_frame_cnt == CNT_LAST);
  assign w_next_x = step_axis(r_blk_x, r_dir_x, XMIN, XMAX);
  assign w_next_y = step_axis(r_blk_y, r_dir_y, YMIN, YMAX);

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_frame_cnt <= '0;
      r_blk_x     <= XMIN_U;
      r_blk_y     <= YMIN_U;
      r_dir_x     <= 1'b0;
      r_dir_y     <= 1'b0;
    end else begin
      if (r_frame_tick && !bus.pause) begin
        r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? '0 : r_frame_cnt + 1'b1;
      end
      if (w_move) begin
        r_blk_x <= w_next_x.pos;
        r_dir_x <= w_next_x.dir;
        r_blk_y <= w_next_y.pos;
        r_dir_y <= w_next_y.dir;
      end
    end
  end

  // ---- pixel stage p0 -> p1 -------------------------------------------------
  assign w_pixel_p0 = pixel_color(bus.pixel_xpos, bus.pixel_ypos, r_blk_x, r_blk_y);

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pixel_data_p1 <= 16'h0000;
    end else begin
      r_pixel_data_p1 <= w_pixel_p0;
    end
  end

  assign bus.pixel_data = r_pixel_data_p1;
  assign bus.blk_x      = r_blk_x;
  assign bus.blk_y      = r_blk_y;
  assign bus.frame_tick = r_frame_tick;

endmodule
